qrisc_regfile_pp: RTL

Parametrised register file for the Qrisc pipeline. It replaces the fixed 32x32 array with configurable width and depth. It adds three things:
- same-cycle write-back forwarding;
- native src2 post-increment/decrement, following the ISA incr field;
- a load scoreboard that stalls decode on pending-load hazards.

It sits between fetch/decode and EX. It supplies val_r1, val_r2 and val_dst to the pipe_struct_t builder.

---
 rtl/qrisc_regfile_pp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/qrisc_regfile_pp.sv
// rtl/qrisc_regfile_pp.sv - parametrised Qrisc register file with forwarding, src2 post-increment and load scoreboard
//
// Purpose: supplies src1/src2/dst operand values to the decode stage one cycle
// after an accepted read request. Same-cycle load-return and write-back values
// are forwarded into the read. src2 can be post-incremented in place. A
// per-register pending bit tracks outstanding memory loads, and stall holds
// off decode while a hazard exists.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rd_en, rd_a1, rd_a2, rd_dst   decode read request and register numbers
//   rd_incr, rd_incr_en           src2 post-increment code and enable
//   rd_dst_load                   request is a memory load into rd_dst
//   rd_v1, rd_v2, rd_vdst         registered operand values
//   rd_valid                      operands hold a request accepted last cycle
//   stall                         combinational: request not accepted
//   wb_en, wb_addr, wb_data       EX write-back port
//   ld_en, ld_addr, ld_data       memory load return port
module qrisc_regfile_pp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_a1,
  input  logic [AW-1:0]   rd_a2,
  input  logic [AW-1:0]   rd_dst,
  input  logic [2:0]      rd_incr,
  input  logic            rd_incr_en,
  input  logic            rd_dst_load,
  output logic [XLEN-1:0] rd_v1,
  output logic [XLEN-1:0] rd_v2,
  output logic [XLEN-1:0] rd_vdst,
  output logic            rd_valid,
  output logic            stall,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;

  logic [XLEN-1:0]   fwd_v1, fwd_v2, fwd_vd;
  logic signed [3:0] incr_delta;
  logic [XLEN-1:0]   incr_val;
  logic              accept;
  logic              incr_we;

  // Load return beats write-back when both target the same register, and
  // both beat the stored value; register 0 is hardwired when R0_ZERO is set.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (ld_en && ld_addr == a)
      v = ld_data;
    else if (wb_en && wb_addr == a)
      v = wb_data;
    else
      v = regs[a];
    if (R0_ZERO != 0 && a == '0)
      v = '0;
    return v;
  endfunction

  // A returning load resolves its own hazard in the same cycle.
  function automatic logic hz(input logic [AW-1:0] a);
    return pending[a] && !(ld_en && ld_addr == a);
  endfunction

  always_comb begin
    fwd_v1 = fwd(rd_a1);
    fwd_v2 = fwd(rd_a2);
    fwd_vd = fwd(rd_dst);
    stall  = rd_en && (hz(rd_a1) || hz(rd_a2) || hz(rd_dst));
    accept = rd_en && !stall;
  end

  always_comb begin
    case (rd_incr)
      3'b001:  incr_delta = 4'sd1;
      3'b010:  incr_delta = 4'sd2;
      3'b011:  incr_delta = 4'sd4;
      3'b101:  incr_delta = -4'sd1;
      3'b110:  incr_delta = -4'sd2;
      3'b111:  incr_delta = -4'sd4;
      default: incr_delta = 4'sd0;
    endcase
    // Based on the forwarded value so a same-cycle ld/wb is not lost.
    incr_val = fwd_v2 + {{(XLEN-4){incr_delta[3]}}, incr_delta};
    incr_we  = accept && rd_incr_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      pending  <= '0;
      rd_v1    <= '0;
      rd_v2    <= '0;
      rd_vdst  <= '0;
      rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!(R0_ZERO != 0 && i == 0)) begin
          if (incr_we && rd_a2 == AW'(i))
            regs[i] <= incr_val;
          else if (ld_en && ld_addr == AW'(i))
            regs[i] <= ld_data;
          else if (wb_en && wb_addr == AW'(i))
            regs[i] <= wb_data;
        end
        // A new load to the register being returned keeps it pending.
        if (accept && rd_dst_load && rd_dst == AW'(i))
          pending[i] <= 1'b1;
        else if (ld_en && ld_addr == AW'(i))
          pending[i] <= 1'b0;
      end
      rd_valid <= accept;
      if (accept) begin
        rd_v1   <= fwd_v1;
        rd_v2   <= fwd_v2;
        rd_vdst <= fwd_vd;
      end
    end
  end

endmodule
